// File: rtl/serial_pkg.sv
// serial_pkg: encodings and helpers shared by the UART transmitter and receiver.
package serial_pkg;

  // Frame sequencer states, in the order they occur on the line.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Values accepted by the PARITY parameter.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Width of a counter that wraps 0..clk_per_bit-1 (never narrower than one bit).
  function automatic int clk_cnt_width(input int clk_per_bit);
    return (clk_per_bit <= 2) ? 1 : $clog2(clk_per_bit);
  endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// serial_baud_tick: free-running bit-period counter. Wraps 0..CLK_PER_BIT-1 and
// pulses tick_o on the last clock of every bit period. restart_i holds the count
// at zero so the next period starts aligned to the cycle restart_i drops.
module serial_baud_tick
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int            CW   = clk_cnt_width(CLK_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on restart or at the end of a bit period, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = ~restart_i & (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// serial_tx: UART transmitter. Accepts one byte per frame over the
// data/new_data/busy handshake and shifts it out LSB-first with a start bit,
// optional parity bit and one or two stop bits. The host can hold off new
// frames with block; a frame already on the line always completes.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = 50,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       new_data,
  input  logic       block,
  output logic       busy,
  output logic       tx
);

  localparam logic       HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic       PARITY_INV = (PARITY == PARITY_ODD);
  localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       block_q;
  logic       tick;
  logic       accept;

  // busy is the OR of two registers: the frame-in-progress flag and the
  // registered flow-control input, so block reaches busy one clock later.
  assign busy   = busy_q | block_q;
  assign accept = new_data & ~busy;
  assign tx     = tx_q;

  serial_baud_tick #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(state_q == ST_IDLE),
    .tick_o   (tick)
  );

  // Frame sequencing, shift register and the registered tx/busy values.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START;
          shift_d   = data;
          parity_d  = (^data) ^ PARITY_INV;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase

    // tx and busy are derived from the next state so both registers line up
    // with the state they describe; the start bit appears the clock after accept.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control registers: reset drives the line idle-high and reports busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b1;
      block_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      block_q   <= block;
    end
  end

  // Byte and parity holding registers; only meaningful once a frame is accepted.
  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
    parity_q <= parity_d;
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed scoreboard bench for serial_tx. Five instances cover the
// parameter combinations; a per-instance monitor decodes every frame on tx and
// compares it with the byte queued when the request was issued.
module tb_serial_tx;

  localparam int NI = 5;

  function automatic int cpb_of(input int i);
    return (i == 4) ? 50 : 4;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
  endfunction
  function automatic int stop_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    data_v [NI];
  logic [NI-1:0] nd_v  = '0;
  logic [NI-1:0] blk_v = '0;
  wire  [NI-1:0] busy_v;
  wire  [NI-1:0] tx_v;

  int n_tests = 0;
  int n_fail  = 0;
  int frames_v [NI];
  bit done = 1'b0;
  logic [7:0] sb0[$], sb1[$], sb2[$], sb3[$], sb4[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_tx #(
      .CLK_PER_BIT(cpb_of(g)),
      .PARITY     (par_of(g)),
      .STOP_BITS  (stop_of(g))
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .data    (data_v[g]),
      .new_data(nd_v[g]),
      .block   (blk_v[g]),
      .busy    (busy_v[g]),
      .tx      (tx_v[g])
    );
  end

  function automatic void sb_push(input int i, input logic [7:0] b);
    case (i)
      0: sb0.push_back(b);
      1: sb1.push_back(b);
      2: sb2.push_back(b);
      3: sb3.push_back(b);
      default: sb4.push_back(b);
    endcase
  endfunction

  function automatic int sb_size(input int i);
    case (i)
      0: return sb0.size();
      1: return sb1.size();
      2: return sb2.size();
      3: return sb3.size();
      default: return sb4.size();
    endcase
  endfunction

  function automatic logic [7:0] sb_pop(input int i);
    case (i)
      0: return sb0.pop_front();
      1: return sb1.pop_front();
      2: return sb2.pop_front();
      3: return sb3.pop_front();
      default: return sb4.pop_front();
    endcase
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Request one byte from a negedge; returns at the accept edge + 1.
  task automatic issue(input int i, input logic [7:0] b, input bit expect_frame);
    data_v[i] = b;
    nd_v[i]   = 1'b1;
    if (expect_frame) sb_push(i, b);
    @(posedge clk);
    #1;
    nd_v[i]   = 1'b0;
    data_v[i] = ~b;
  endtask

  // Frame decoder: every clock of a frame is compared with the expected level.
  task automatic monitor(input int idx);
    int cpb, nb, first_bad, gap;
    logic prev, aborted, got;
    logic bits [12];
    logic [7:0] b;
    cpb  = cpb_of(idx);
    nb   = 9 + ((par_of(idx) != 0) ? 1 : 0) + stop_of(idx);
    prev = 1'b1;
    gap  = 0;
    while (!done) begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b1;
        gap  = 0;
      end else if (prev && (tx_v[idx] == 1'b0)) begin
        if (sb_size(idx) == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame u%0d: start bit at %0t, expected none", idx, $time);
          prev = 1'b0;
        end else begin
          b = sb_pop(idx);
          for (int k = 0; k < 12; k++) bits[k] = 1'b1;
          bits[0] = 1'b0;
          for (int k = 0; k < 8; k++) bits[k+1] = b[k];
          if (par_of(idx) == 1) bits[9] = ^b;
          else if (par_of(idx) == 2) bits[9] = ~^b;
          if (idx == 4 && frames_v[idx] > 0) begin
            n_tests++;
            if (gap > 1) begin
              n_fail++;
              $display("FAIL inter_frame_gap u%0d: got %0d idle clks, expected at most 1", idx, gap);
            end
          end
          first_bad = -1;
          aborted   = 1'b0;
          got       = 1'b0;
          for (int j = 1; j < nb * cpb; j++) begin
            @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (first_bad < 0 && tx_v[idx] !== bits[j / cpb]) begin
              first_bad = j;
              got       = tx_v[idx];
            end
          end
          if (!aborted) begin
            n_tests++;
            if (first_bad >= 0) begin
              n_fail++;
              $display("FAIL frame u%0d byte %02h: clk %0d got tx=%b, expected %b",
                       idx, b, first_bad, got, bits[first_bad / cpb]);
            end
            frames_v[idx]++;
          end
          prev = 1'b1;
          gap  = 0;
        end
      end else begin
        prev = tx_v[idx];
        if (tx_v[idx]) gap++;
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
      monitor(4);
    join_none
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] t1_bits;
    logic [7:0] stream [14];
    int cnt, cnt_b, cb1, cb2, cb3, st3, k, cyc;

    t1_bits = 10'b1011010000;
    stream  = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E,
                8'h81, 8'h3C, 8'hC3, 8'h12, 8'h34, 8'hF0, 8'h0F};
    for (int i = 0; i < NI; i++) data_v[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check1($sformatf("reset_tx_u%0d", i), tx_v[i], 1'b1);
      check1($sformatf("reset_busy_u%0d", i), busy_v[i], 1'b1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    check1("busy_right_after_release", busy_v[0], 1'b1);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check1($sformatf("busy_after_release_u%0d", i), busy_v[i], 1'b0);

    // Test 1: 0x68, no parity, one stop bit
    issue(0, 8'h68, 1'b1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_v[0]) cnt++;
      if (c == 0) check1("t1_tx_falls_after_accept", tx_v[0], 1'b0);
      if (c % 4 == 2) check1($sformatf("t1_bit%0d", c / 4), tx_v[0], t1_bits[c / 4]);
    end
    checkn("t1_busy_clks", cnt, 40);
    @(negedge clk);
    check1("t1_busy_low_after_frame", busy_v[0], 1'b0);

    // Test 2: second request while busy is dropped
    issue(0, 8'h41, 1'b1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_v[0]) cnt++;
      if (c == 4) begin
        check1("t2_busy_at_second_request", busy_v[0], 1'b1);
        data_v[0] = 8'h42;
        nd_v[0]   = 1'b1;
      end
      if (c == 5) nd_v[0] = 1'b0;
    end
    checkn("t2_busy_clks", cnt, 40);
    @(negedge clk);
    check1("t2_busy_low_after_frame", busy_v[0], 1'b0);

    // Test 3a: blocked from idle, request ignored
    blk_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check1("t3_busy_blocked", busy_v[0], 1'b1);
    issue(0, 8'h33, 1'b0);
    cnt   = 0;
    cnt_b = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (tx_v[0]) cnt++;
      if (busy_v[0]) cnt_b++;
    end
    checkn("t3_tx_idle_while_blocked", cnt, 12);
    checkn("t3_busy_while_blocked", cnt_b, 12);
    blk_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check1("t3_busy_after_unblock", busy_v[0], 1'b0);

    // Test 3b: block rises mid-frame
    issue(0, 8'h5A, 1'b1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 6) blk_v[0] = 1'b1;
      if (busy_v[0]) cnt++;
    end
    checkn("t3b_busy_clks", cnt, 40);
    cnt   = 0;
    cnt_b = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy_v[0]) cnt++;
      if (tx_v[0]) cnt_b++;
    end
    checkn("t3b_busy_held_by_block", cnt, 5);
    checkn("t3b_tx_idle_after_frame", cnt_b, 5);
    blk_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check1("t3b_busy_after_unblock", busy_v[0], 1'b0);

    // Test 5: reset during data bit 3 of 0xC3 (bit 3 is 0)
    issue(0, 8'hC3, 1'b1);
    for (int c = 0; c < 18; c++) @(negedge clk);
    check1("t5_tx_before_reset", tx_v[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check1("t5_tx_async", tx_v[0], 1'b1);
    check1("t5_busy_async", busy_v[0], 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check1("t5_busy_at_release", busy_v[0], 1'b1);
    @(posedge clk);
    @(negedge clk);
    check1("t5_busy_after_release", busy_v[0], 1'b0);
    check1("t5_tx_after_release", tx_v[0], 1'b1);
    issue(0, 8'h55, 1'b1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_v[0]) cnt++;
    end
    checkn("t5_fresh_busy_clks", cnt, 40);
    @(negedge clk);
    check1("t5_busy_low_after_frame", busy_v[0], 1'b0);

    // Test 4: parity variants and two stop bits, 0x07 on each
    for (int i = 1; i <= 3; i++) begin
      data_v[i] = 8'h07;
      nd_v[i]   = 1'b1;
      sb_push(i, 8'h07);
    end
    @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) nd_v[i] = 1'b0;
    cb1 = 0;
    cb2 = 0;
    cb3 = 0;
    st3 = 0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      if (busy_v[1]) cb1++;
      if (busy_v[2]) cb2++;
      if (busy_v[3]) cb3++;
      if (c >= 36 && tx_v[3]) st3++;
      if (c == 34) check1("t4_last_data_bit_u3", tx_v[3], 1'b0);
      if (c == 38) begin
        check1("t4_even_parity_bit", tx_v[1], 1'b1);
        check1("t4_odd_parity_bit", tx_v[2], 1'b0);
      end
    end
    checkn("t4_even_busy_clks", cb1, 44);
    checkn("t4_odd_busy_clks", cb2, 44);
    checkn("t4_stop2_busy_clks", cb3, 44);
    checkn("t4_stop2_high_clks", st3, 8);
    @(negedge clk);
    check1("t4_stop2_busy_low", busy_v[3], 1'b0);

    // Test 6: 14-byte stream gated by busy at CLK_PER_BIT=50
    k   = 0;
    cyc = 0;
    while (k < 14 && cyc < 10000) begin
      @(posedge clk);
      #1;
      if (!busy_v[4]) begin
        data_v[4] = stream[k];
        nd_v[4]   = 1'b1;
        sb_push(4, stream[k]);
        k++;
      end else begin
        nd_v[4] = 1'b0;
      end
      cyc++;
    end
    @(posedge clk);
    #1 nd_v[4] = 1'b0;
    while (busy_v[4] && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    checkn("t6_bytes_issued", k, 14);
    checkn("t6_frames_seen", frames_v[4], 14);

    for (int i = 0; i < NI; i++) checkn($sformatf("sb_empty_u%0d", i), sb_size(i), 0);

    done = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
